apb_rr_bridge: RTL and testbench

Multi-requester APB master. Shares one APB bus among N_REQ local requesters with round-robin arbitration. Sequences the IDLE/SETUP/ACCESS protocol and returns read data and error status to the granted requester. Sits between local command sources (CPU stub, DMA, test sequencers) and the APB interconnect/slaves.

---
 rtl/apb_rr_bridge_pkg.sv | 16 +
 rtl/apb_rr_arbiter.sv | 37 +++
 rtl/apb_rr_bridge.sv | 157 +++++++++++++++
 tb/tb_apb_rr_bridge.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_rr_bridge_pkg.sv
// Shared types and defaults for the round-robin APB bridge.
package apb_rr_bridge_pkg;

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    localparam int unsigned DefNReq       = 2;
    localparam int unsigned DefAddrW      = 32;
    localparam int unsigned DefDataW      = 32;
    localparam int unsigned DefTimeoutCyc = 16;

    // Index width that stays at least one bit for a single requester.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping to 0.
module apb_rr_arbiter
    import apb_rr_bridge_pkg::*;
#(
    parameter int unsigned N_REQ = DefNReq,
    parameter int unsigned IW    = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    idx
);

    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        // Upper segment [ptr, N_REQ) outranks the wrapped segment [0, ptr).
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                idx    = IW'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i] && (i < int'(ptr))) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                idx    = IW'(i);
            end
        end
    end

endmodule

// File: rtl/apb_rr_bridge.sv
// Multi-requester APB master: round-robin grant, SETUP/ACCESS sequencing,
// response routing and a stall timeout that abandons a hung slave.
module apb_rr_bridge
    import apb_rr_bridge_pkg::*;
#(
    parameter int unsigned N_REQ       = DefNReq,
    parameter int unsigned ADDR_W      = DefAddrW,
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned TIMEOUT_CYC = DefTimeoutCyc
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ-1:0]         req_write,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_wdata,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic                     PSEL,
    output logic                     PENABLE,
    output logic                     PWRITE,
    output logic [ADDR_W-1:0]        PADDR,
    output logic [DATA_W-1:0]        PWDATA,
    input  logic [DATA_W-1:0]        PRDATA,
    input  logic                     PREADY,
    input  logic                     PSLVERR
);

    localparam int unsigned IW = idx_width(N_REQ);
    localparam int unsigned CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    state_e             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d, owner_q, owner_d, gnt_idx;
    logic [N_REQ-1:0]   gnt, rsp_valid_q, rsp_valid_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]  paddr_q, paddr_d, sel_addr;
    logic [DATA_W-1:0]  pwdata_q, pwdata_d, sel_wdata, rsp_rdata_q, rsp_rdata_d;
    logic               sel_write, rsp_err_q, rsp_err_d, timeout, done;

    apb_rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
                sel_write = req_write[i];
            end
        end
    end

    // Fires on the edge that would make the stall count reach TIMEOUT_CYC.
    assign timeout = (TIMEOUT_CYC != 0) && (state_q == StAccess) && !PREADY &&
                     (cnt_q == CW'(TIMEOUT_CYC - 1));
    assign done    = (state_q == StAccess) && (PREADY || timeout);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            StIdle: begin
                if (|gnt) begin
                    state_d  = StSetup;
                    owner_d  = gnt_idx;
                    psel_d   = 1'b1;
                    pwrite_d = sel_write;
                    paddr_d  = sel_addr;
                    pwdata_d = sel_write ? sel_wdata : '0;
                end
            end
            StSetup: begin
                state_d   = StAccess;
                penable_d = 1'b1;
            end
            StAccess: begin
                if (done) begin
                    state_d     = StIdle;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    cnt_d       = '0;
                    ptr_d       = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
                    rsp_valid_d = N_REQ'(1) << owner_q;
                    rsp_rdata_d = (PREADY && !pwrite_q) ? PRDATA : '0;
                    rsp_err_d   = PREADY ? PSLVERR : 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (PRESETn && (state_q == StIdle)) ? gnt : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_rr_bridge.sv
// Directed plus randomized bench; the bench plays the APB slave and predicts
// grants, bus fields and responses from an arbitration/memory model.
module tb_apb_rr_bridge;

    localparam int N   = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic              PCLK, PRESETn;
    logic [N-1:0]      req_valid, req_ready, req_write, rsp_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [DW-1:0]     rsp_rdata, PRDATA, PWDATA;
    logic [AW-1:0]     PADDR;
    logic              rsp_err, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

    apb_rr_bridge #(
        .N_REQ       (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int          n_cmp, n_err;
    int          ptr_m;
    logic [31:0] mem [16];
    bit          hold, noise;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] setbit(input logic [N-1:0] v, input int i, input bit b);
        return (v & ~(N'(1) << i)) | (N'(b) << i);
    endfunction

    // Round-robin rule: first valid requester scanning upward from ptr, modulo N.
    function automatic int pick(input logic [N-1:0] v, input int p);
        int j;
        for (int k = 0; k < N; k++) begin
            j = (p + k) % N;
            if (((v >> j) & N'(1)) != '0) return j;
        end
        return -1;
    endfunction

    task automatic set_cmd(input int r, input bit wr, input logic [31:0] a,
                           input logic [31:0] d);
        req_write = setbit(req_write, r, wr);
        req_addr  = (req_addr & ~((N*AW)'(32'hFFFF_FFFF) << (r*AW))) | ((N*AW)'(a) << (r*AW));
        req_wdata = (req_wdata & ~((N*DW)'(32'hFFFF_FFFF) << (r*DW))) | ((N*DW)'(d) << (r*DW));
        req_valid = setbit(req_valid, r, 1'b1);
    endtask

    // One transfer from grant to response; ends in the response (IDLE) cycle.
    task automatic xfer(input int waits, input bit serr, input bit tmo);
        int          own, n;
        bit          wr;
        logic [31:0] a, d, exp_rd, exp_wd;
        logic [N-1:0] oh;
        #1;
        own = pick(req_valid, ptr_m);
        if (own < 0) begin
            n_err++;
            $display("FAIL xfer_setup: no request pending at time %0t", $time);
            return;
        end
        oh     = N'(1) << own;
        wr     = 1'((req_write >> own) & N'(1));
        a      = AW'(req_addr >> (own*AW));
        d      = DW'(req_wdata >> (own*DW));
        exp_wd = wr ? d : 32'h0;
        exp_rd = wr ? 32'h0 : mem[a[5:2]];
        chk("grant", 64'(req_ready), 64'(oh));
        @(posedge PCLK); #1;
        if (!hold) req_valid = setbit(req_valid, own, 1'b0);
        chk("setup_sel", 64'({PSEL, PENABLE}), 64'(2'b10));
        chk("setup_paddr", 64'(PADDR), 64'(a));
        chk("setup_pwrite", 64'(PWRITE), 64'(wr));
        chk("setup_pwdata", 64'(PWDATA), 64'(exp_wd));
        chk("setup_ready", 64'(req_ready), 64'(0));
        chk("setup_rsp", 64'(rsp_valid), 64'(0));
        n = tmo ? TMO : waits + 1;
        for (int i = 0; i < n; i++) begin
            @(posedge PCLK); #1;
            chk("access_sel", 64'({PSEL, PENABLE}), 64'(2'b11));
            chk("access_paddr", 64'(PADDR), 64'(a));
            chk("access_pwdata", 64'(PWDATA), 64'(exp_wd));
            chk("access_rsp", 64'(rsp_valid), 64'(0));
            if (noise) req_valid = setbit(req_valid, (own + 1) % N, 1'($urandom));
            PREADY  = !tmo && (i == waits);
            PRDATA  = (wr || !PREADY) ? $urandom : mem[a[5:2]];
            PSLVERR = PREADY ? serr : 1'($urandom);
        end
        @(posedge PCLK); #1;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        chk("rsp_valid", 64'(rsp_valid), 64'(oh));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(tmo ? 32'h0 : exp_rd));
        chk("rsp_err", 64'(rsp_err), 64'(tmo | serr));
        chk("idle_sel", 64'({PSEL, PENABLE}), 64'(0));
        if (wr && !tmo && !serr) mem[a[5:2]] = d;
        ptr_m = (own + 1) % N;
    endtask

    initial begin
        logic [N-1:0] pat;
        n_cmp = 0; n_err = 0; ptr_m = 0; hold = 0; noise = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        PRESETn = 1'b0;
        req_valid = '1; req_write = '0; req_addr = '0; req_wdata = '0;
        PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;

        // Reset state, with requests pending
        repeat (2) @(posedge PCLK); #1;
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_sel", 64'({PSEL, PENABLE, PWRITE}), 64'(0));
        chk("rst_paddr", 64'(PADDR), 64'(0));
        chk("rst_pwdata", 64'(PWDATA), 64'(0));
        chk("rst_rsp", 64'({rsp_valid, rsp_err}), 64'(0));
        chk("rst_rdata", 64'(rsp_rdata), 64'(0));
        req_valid = '0;
        PRESETn   = 1'b1;

        // Requester 0: write 17 then read back, zero wait states
        set_cmd(0, 1'b1, 32'h0, 32'd17);
        xfer(0, 1'b0, 1'b0);
        set_cmd(0, 1'b0, 32'h0, 32'h0);
        xfer(0, 1'b0, 1'b0);
        chk("rd17_value", 64'(rsp_rdata), 64'(17));

        // Requester 1: "APB" to addr 8, read back with 3 wait states
        set_cmd(1, 1'b1, 32'h8, 32'h0041_5042);
        xfer(0, 1'b0, 1'b0);
        set_cmd(1, 1'b0, 32'h8, 32'h0);
        xfer(3, 1'b0, 1'b0);
        chk("apb_value", 64'(rsp_rdata), 64'(32'h0041_5042));

        // Both requesters held valid: alternation
        hold = 1;
        set_cmd(0, 1'($urandom), {26'h0, 4'($urandom), 2'b00}, $urandom);
        set_cmd(1, 1'($urandom), {26'h0, 4'($urandom), 2'b00}, $urandom);
        for (int k = 0; k < 4; k++) xfer($urandom_range(0, 2), 1'b0, 1'b0);
        hold = 0;
        req_valid = '0;

        // Slave error on addr 4, then a clean transfer
        set_cmd(0, 1'b0, 32'h4, 32'h0);
        xfer(1, 1'b1, 1'b0);
        set_cmd(0, 1'b0, 32'h4, 32'h0);
        xfer(0, 1'b0, 1'b0);

        // Hung slave: timeout after TMO stalled ACCESS cycles
        set_cmd(1, 1'b1, 32'hC, $urandom);
        xfer(0, 1'b0, 1'b1);

        // Randomized traffic with noisy request lines
        noise = 1;
        for (int k = 0; k < 20; k++) begin
            pat = N'($urandom_range(1, 3));
            req_valid = '0;
            for (int r = 0; r < N; r++)
                if (((pat >> r) & N'(1)) != '0)
                    set_cmd(r, 1'($urandom), {26'h0, 4'($urandom), 2'b00}, $urandom);
            xfer($urandom_range(0, 3), ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
        end
        noise = 0;
        req_valid = '0;

        // Reset mid-ACCESS: move ptr to 1 first, then abort a transfer by requester 1
        set_cmd(0, 1'b1, 32'h10, $urandom);
        xfer(0, 1'b0, 1'b0);
        hold = 1;
        set_cmd(0, 1'b0, 32'h14, 32'h0);
        set_cmd(1, 1'b0, 32'h18, 32'h0);
        #1;
        chk("pre_rst_grant", 64'(req_ready), 64'(2'b10));
        @(posedge PCLK); #1;
        @(posedge PCLK); #1;
        chk("pre_rst_access", 64'({PSEL, PENABLE}), 64'(2'b11));
        #2;
        PRESETn = 1'b0;
        #1;
        chk("mid_rst_sel", 64'({PSEL, PENABLE}), 64'(0));
        chk("mid_rst_ready", 64'(req_ready), 64'(0));
        for (int i = 0; i < 2; i++) begin
            @(posedge PCLK); #1;
            chk("mid_rst_rsp", 64'(rsp_valid), 64'(0));
        end
        PRESETn = 1'b1;
        ptr_m   = 0;
        xfer(0, 1'b0, 1'b0);
        xfer(1, 1'b0, 1'b0);
        hold = 0;
        req_valid = '0;
        @(posedge PCLK); #1;
        chk("final_idle", 64'({PSEL, PENABLE, rsp_valid}), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
